// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// slave is the unit itself; master is whoever issues requests and owns the memory.
//
// Handshake: start is a one-cycle request that is honoured only while busy is low.
// The unit raises busy on the following cycle and keeps it high until the cycle
// after done. done is a single-cycle pulse; fault and load_data are valid with it.
// There is no back-pressure: the requester must be ready for done at any time.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  start;
  logic                  is_store;
  logic [2:0]            funct3;
  logic [ADDR_WIDTH-1:0] addr;
  logic [63:0]           store_data;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [63:0]           mem_wdata;
  logic                  mem_wr;
  logic [63:0]           mem_rdata;
  logic [63:0]           load_data;
  logic                  busy;
  logic                  done;
  logic                  fault;
  logic [2:0]            dbg_state;

  modport slave (
    input  start, is_store, funct3, addr, store_data, mem_rdata,
    output mem_raddr, mem_waddr, mem_wdata, mem_wr,
    output load_data, busy, done, fault, dbg_state
  );

  modport master (
    output start, is_store, funct3, addr, store_data, mem_rdata,
    input  mem_raddr, mem_waddr, mem_wdata, mem_wr,
    input  load_data, busy, done, fault, dbg_state
  );
endinterface

// File: rtl/load_store_unit.sv
// Multicycle RV64I load/store stage against a doubleword-wide memory with a
// one-cycle synchronous read. Sub-doubleword stores use read-modify-write.
module load_store_unit #(
  parameter int ADDR_WIDTH = 64
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_RDW  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // Request captured at start; the access never looks at the live inputs again.
  logic                  is_store_q;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [63:0]           store_data_q;
  logic                  fault_q;
  logic [63:0]           wbuf_q;
  logic [63:0]           load_q;

  logic                  req_fault;
  logic                  req_dword_store;
  logic                  dword_q;
  logic [5:0]            lane_shift;
  logic [63:0]           lane;
  logic [63:0]           load_ext;
  logic [63:0]           size_mask;
  logic [63:0]           merged;

  // Classify the incoming request: illegal encodings first, then misalignment.
  always_comb begin
    logic illegal;
    logic misaligned;
    illegal    = (bus.funct3 == 3'b111) || (bus.is_store && bus.funct3[2]);
    misaligned = 1'b0;
    case (bus.funct3[1:0])
      2'b01:   misaligned = bus.addr[0];
      2'b10:   misaligned = |bus.addr[1:0];
      2'b11:   misaligned = |bus.addr[2:0];
      default: misaligned = 1'b0;
    endcase
    req_fault       = illegal || misaligned;
    req_dword_store = bus.is_store && (bus.funct3[1:0] == 2'b11);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decision; a full doubleword store needs no read.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (req_fault)            state_next = S_DONE;
          else if (req_dword_store) state_next = S_WR;
          else                      state_next = S_RD;
        end
      end
      S_RD:    state_next = S_RDW;
      S_RDW:   state_next = is_store_q ? S_WR : S_DONE;
      S_WR:    state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Lane extraction for loads and lane merge for sub-doubleword stores.
  always_comb begin
    dword_q    = (funct3_q[1:0] == 2'b11);
    lane_shift = {addr_q[2:0], 3'b000};
    lane       = bus.mem_rdata >> lane_shift;
    case (funct3_q)
      3'b000:  load_ext = {{56{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{48{lane[15]}}, lane[15:0]};
      3'b010:  load_ext = {{32{lane[31]}}, lane[31:0]};
      3'b011:  load_ext = lane;
      3'b100:  load_ext = {56'd0, lane[7:0]};
      3'b101:  load_ext = {48'd0, lane[15:0]};
      3'b110:  load_ext = {32'd0, lane[31:0]};
      default: load_ext = 64'd0;
    endcase
    case (funct3_q[1:0])
      2'b00:   size_mask = 64'h0000_0000_0000_00FF;
      2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    merged = (bus.mem_rdata & ~(size_mask << lane_shift))
           | ((store_data_q & size_mask) << lane_shift);
  end

  // Capture the request at start and register read results in RDW.
  always_ff @(posedge clock) begin
    if (reset) begin
      is_store_q   <= 1'b0;
      funct3_q     <= 3'd0;
      addr_q       <= '0;
      store_data_q <= 64'd0;
      fault_q      <= 1'b0;
      wbuf_q       <= 64'd0;
      load_q       <= 64'd0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        is_store_q   <= bus.is_store;
        funct3_q     <= bus.funct3;
        addr_q       <= bus.addr;
        store_data_q <= bus.store_data;
        fault_q      <= req_fault;
      end
      if (state == S_RDW) begin
        if (is_store_q) wbuf_q <= merged;
        else            load_q <= load_ext;
      end
    end
  end

  // Outputs decoded from the state; fault is only visible alongside done.
  always_comb begin
    bus.busy      = (state != S_IDLE);
    bus.done      = (state == S_DONE);
    bus.fault     = (state == S_DONE) && fault_q;
    bus.mem_wr    = (state == S_WR);
    bus.mem_wdata = dword_q ? store_data_q : wbuf_q;
    bus.mem_raddr = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    bus.mem_waddr = {addr_q[ADDR_WIDTH-1:3], 3'b000};
    bus.load_data = load_q;
    bus.dbg_state = state;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed test-plan sequences plus random traffic,
// checked cycle by cycle against a byte-level model of memory and timing.
module tb_load_store_unit;

  logic clock;
  logic reset;

  load_store_unit_if #(.ADDR_WIDTH(64)) bus ();

  load_store_unit #(.ADDR_WIDTH(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        busy;
    logic        done;
    logic        fault;
    logic        wr;
    logic [63:0] waddr;
    logic [63:0] wdata;
    logic [63:0] ld;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] dut_mem [0:63];
  logic [63:0] ref_mem [0:63];
  logic [63:0] model_ld;
  bit          chk_en;
  int          checks;
  int          failures;
  int          wr_count;
  logic [63:0] last_waddr;
  logic [63:0] last_wdata;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic b, input logic d, input logic f, input logic w,
                              input logic [63:0] wa, input logic [63:0] wd, input logic [63:0] l);
    exp_t e;
    e.busy = b; e.done = d; e.fault = f; e.wr = w;
    e.waddr = wa; e.wdata = wd; e.ld = l;
    return e;
  endfunction

  // ---------------- data memory (also seeds the model copy) ----------------
  initial begin
    logic [63:0] v;
    for (int i = 0; i < 64; i++) begin
      v = {$urandom, $urandom};
      if (i == 32) v = 64'h8877665544332211;
      dut_mem[i] = v;
      ref_mem[i] = v;
    end
    forever begin
      @(posedge clock);
      bus.mem_rdata <= dut_mem[bus.mem_raddr[8:3]];
      if (bus.mem_wr) dut_mem[bus.mem_waddr[8:3]] <= bus.mem_wdata;
    end
  end

  // ---------------- reference model ----------------
  // Pushes one expectation per cycle from the cycle after start to the done cycle.
  task automatic model_push(input logic st, input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] sd, output int lat);
    int          n;
    int          off;
    int          idx;
    bit          flt;
    logic [63:0] dw;
    logic [63:0] v;
    logic [63:0] old_ld;
    n      = 1 << f3[1:0];
    off    = int'(a[2:0]);
    idx    = int'(a[8:3]);
    old_ld = model_ld;
    flt    = (f3 == 3'b111) || (st && f3[2]) || ((a % 64'(n)) != 0);
    if (flt) begin
      lat = 1;
      exp_q.push_back(mk(1, 1, 1, 0, 0, 0, old_ld));
    end else if (!st) begin
      dw = ref_mem[idx];
      v  = 64'd0;
      for (int i = 0; i < n; i++)
        v = v | (((dw >> (8 * (off + i))) & 64'hFF) << (8 * i));
      if (!f3[2] && n < 8 && v[8 * n - 1]) v = v | (~64'd0 << (8 * n));
      lat = 3;
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, old_ld));
      exp_q.push_back(mk(1, 0, 0, 0, 0, 0, old_ld));
      exp_q.push_back(mk(1, 1, 0, 0, 0, 0, v));
      model_ld = v;
    end else begin
      dw = ref_mem[idx];
      for (int i = 0; i < n; i++)
        dw = (dw & ~(64'hFF << (8 * (off + i)))) | (((sd >> (8 * i)) & 64'hFF) << (8 * (off + i)));
      ref_mem[idx] = dw;
      if (n == 8) begin
        lat = 2;
      end else begin
        lat = 4;
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, old_ld));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 0, old_ld));
      end
      exp_q.push_back(mk(1, 0, 0, 1, a & ~64'h7, dw, old_ld));
      exp_q.push_back(mk(1, 1, 0, 0, 0, 0, old_ld));
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (bus.mem_wr === 1'b1) begin
        wr_count++;
        last_waddr = bus.mem_waddr;
        last_wdata = bus.mem_wdata;
      end
      if (chk_en) begin
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = mk(0, 0, 0, 0, 0, 0, model_ld);
        chk("busy",      64'(bus.busy),   64'(e.busy));
        chk("done",      64'(bus.done),   64'(e.done));
        chk("fault",     64'(bus.fault),  64'(e.fault));
        chk("mem_wr",    64'(bus.mem_wr), 64'(e.wr));
        chk("load_data", bus.load_data,   e.ld);
        if (e.wr) begin
          chk("mem_waddr", bus.mem_waddr, e.waddr);
          chk("mem_wdata", bus.mem_wdata, e.wdata);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble_inputs();
    bus.is_store   = 1'($urandom_range(0, 1));
    bus.funct3     = 3'($urandom_range(0, 7));
    bus.addr       = 64'($urandom_range(0, 511));
    bus.store_data = {$urandom, $urandom};
  endtask

  // Start one access; returns on the falling edge inside its done cycle.
  // hold keeps start asserted throughout, which the unit must ignore.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] sd, input bit hold);
    int lat;
    @(negedge clock);
    bus.start      = 1'b1;
    bus.is_store   = st;
    bus.funct3     = f3;
    bus.addr       = a;
    bus.store_data = sd;
    model_push(st, f3, a, sd, lat);
    for (int k = 0; k < lat; k++) begin
      @(negedge clock);
      bus.start = hold;
      scramble_inputs();
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
  endtask

  // SB interrupted by reset during its RDW cycle.
  task automatic reset_mid_store();
    int wr_before;
    wr_before = wr_count;
    @(negedge clock);
    bus.start = 1'b1; bus.is_store = 1'b1; bus.funct3 = 3'b000;
    bus.addr = 64'h103; bus.store_data = 64'hA5;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, model_ld));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, model_ld));
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_ld = 64'd0;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_busy",  64'(bus.busy), 64'd0);
    chk("rst_done",  64'(bus.done), 64'd0);
    chk("rst_ld",    bus.load_data, 64'd0);
    idle(4);
    chk("rst_no_wr", 64'(wr_count - wr_before), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          wr_before;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] a;
    checks = 0; failures = 0; wr_count = 0;
    last_waddr = '0; last_wdata = '0;
    model_ld = 64'd0;
    chk_en = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0; bus.is_store = 1'b0; bus.funct3 = 3'd0;
    bus.addr = 64'd0; bus.store_data = 64'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_ld",   bus.load_data,    64'd0);
    chk("reset_busy", 64'(bus.busy),    64'd0);
    chk("reset_done", 64'(bus.done),    64'd0);
    chk("reset_wr",   64'(bus.mem_wr),  64'd0);
    idle(2);

    // Loads from the seeded dword at 0x100.
    issue(1'b0, 3'b000, 64'h107, 64'd0, 0);
    chk("lb_done", 64'(bus.done), 64'd1);
    chk("lb_val",  bus.load_data, 64'hFFFFFFFFFFFFFF88);
    issue(1'b0, 3'b100, 64'h107, 64'd0, 0);
    chk("lbu_val", bus.load_data, 64'h0000000000000088);
    issue(1'b0, 3'b010, 64'h104, 64'd0, 0);
    chk("lw_val",  bus.load_data, 64'hFFFFFFFF88776655);
    issue(1'b0, 3'b110, 64'h104, 64'd0, 0);
    chk("lwu_val", bus.load_data, 64'h0000000088776655);

    // SH read-modify-write.
    wr_before = wr_count;
    issue(1'b1, 3'b001, 64'h102, 64'h12345678_0000BEEF, 0);
    chk("sh_done",  64'(bus.done), 64'd1);
    chk("sh_wrcnt", 64'(wr_count - wr_before), 64'd1);
    chk("sh_waddr", last_waddr, 64'h100);
    chk("sh_wdata", last_wdata, 64'h88776655BEEF2211);

    // SD then LD of the same dword.
    wr_before = wr_count;
    issue(1'b1, 3'b011, 64'h108, 64'hDEADBEEFCAFEF00D, 0);
    chk("sd_wrcnt", 64'(wr_count - wr_before), 64'd1);
    chk("sd_wdata", last_wdata, 64'hDEADBEEFCAFEF00D);
    issue(1'b0, 3'b011, 64'h108, 64'd0, 0);
    chk("ld_val", bus.load_data, 64'hDEADBEEFCAFEF00D);

    // Faults: no write, load_data unchanged.
    wr_before = wr_count;
    issue(1'b0, 3'b010, 64'h102, 64'd0, 0);
    chk("flt_lw", 64'(bus.fault), 64'd1);
    issue(1'b0, 3'b001, 64'h101, 64'd0, 0);
    chk("flt_lh", 64'(bus.fault), 64'd1);
    issue(1'b1, 3'b100, 64'h100, 64'h55, 0);
    chk("flt_st100", 64'(bus.fault), 64'd1);
    issue(1'b0, 3'b111, 64'h100, 64'd0, 0);
    chk("flt_ld111", 64'(bus.fault), 64'd1);
    chk("flt_ld_keep", bus.load_data, 64'hDEADBEEFCAFEF00D);
    chk("flt_no_wr",   64'(wr_count - wr_before), 64'd0);

    // start held through an LD, then a back-to-back request in the first idle cycle.
    issue(1'b0, 3'b011, 64'h108, 64'd0, 1);
    issue(1'b0, 3'b011, 64'h100, 64'd0, 0);
    chk("b2b_ld", bus.load_data, 64'h88776655BEEF2211);
    idle(1);

    reset_mid_store();

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 64'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f3[1:0]) - 1);
      issue(st, f3, a, {$urandom, $urandom}, bit'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(4);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multicycle data-memory access stage. It sits downstream of the 64-bit ALU and the instruction register, and upstream of register-file write-back. It receives a byte address (ALU result), funct3 and store data from the control unit. It performs RV64I loads (LB/LH/LW/LD/LBU/LHU/LWU) and stores (SB/SH/SW/SD) against a 64-bit-wide, doubleword-addressed data memory with a 1-cycle synchronous read. Sub-doubleword stores use read-modify-write.

Parameters:
ADDR_WIDTH, 64, width of addr, mem_raddr and mem_waddr

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request pulse; sampled only in IDLE
is_store  in  1  1 = store, 0 = load; captured at start
funct3  in  3  access size/sign (instr[14:12]); captured at start
addr  in  ADDR_WIDTH  byte address; captured at start
store_data  in  64  rs2 value; low bytes used per size; captured at start
mem_raddr  out  ADDR_WIDTH  doubleword-aligned read address {addr_q[ADDR_WIDTH-1:3],3'b000}
mem_waddr  out  ADDR_WIDTH  same value as mem_raddr
mem_wdata  out  64  merged write doubleword
mem_wr  out  1  memory write strobe, one cycle
mem_rdata  in  64  memory read data; valid the cycle after mem_raddr is stable
load_data  out  64  extended load result, registered
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
fault  out  1  valid with done: misaligned or illegal funct3

Behaviour:
- Reset (synchronous): state=IDLE; load_data=0, mem_wr=0, done=0, busy=0, fault=0. Internal capture registers are cleared to 0.
- States: IDLE, RD, RDW, WR, DONE. Encoding is free.
- IDLE + start: capture is_store, funct3, addr, store_data. Then evaluate, in priority order:
  - Illegal: funct3=111, or store with funct3[2]=1 → DONE with fault=1. No memory access.
  - Misaligned: halfword with addr[0]≠0, word with addr[1:0]≠0, or doubleword with addr[2:0]≠0 → DONE with fault=1. No memory access.
  - SD → WR.
  - Any other access → RD.
- RD: address is held and presented to memory → RDW.
- RDW: mem_rdata is valid this cycle.
  - Load: extract the lane at byte offset addr_q[2:0] (little-endian). Sign-extend for funct3 000/001/010; zero-extend for 100/101/110; no extension for 011. Register the result into load_data → DONE.
  - Store: replace the selected byte/half/word lane of mem_rdata with the low bytes of store_data. Register the result into an internal write buffer → WR.
- WR: mem_wr=1 for exactly this cycle. mem_wdata is the write buffer (SB/SH/SW) or store_data (SD) → DONE.
- DONE: done=1 for one cycle; fault holds the decision made at start → IDLE. fault is 0 whenever done=0.
- Latency, counted as cycles from the start cycle to the done cycle: load 3, SD 2, SB/SH/SW 4, fault 1.
- start while busy is ignored and not queued. start in the DONE cycle is also ignored; the next request must arrive in IDLE.
- load_data holds its value until the next successful load completes. Stores and faults do not change it.
- mem_wr is 0 in every state except WR. mem_wdata is don't-care outside WR.
- Reset mid-operation: the state returns to IDLE on that edge. mem_wr is 0 from the next cycle, and any pending store is abandoned (no write).
- Inputs are sampled only at start. Changes to addr, store_data or funct3 while busy do not affect the access in progress.

Test Plan:
- Memory dword @0x100 = 0x8877665544332211. LB addr=0x107 → done at cycle+3, load_data=0xFFFFFFFFFFFFFF88. LBU same address → 0x0000000000000088. LW addr=0x104 → 0xFFFFFFFF88776655. LWU addr=0x104 → 0x0000000088776655.
- SH addr=0x102, store_data=0x12345678_0000BEEF, same initial dword → mem_wr high exactly once, at cycle+3, with mem_waddr=0x100 and mem_wdata=0x88776655BEEF2211. done at cycle+4.
- SD addr=0x108, store_data=0xDEADBEEFCAFEF00D → mem_wr at cycle+1 with that exact data; done at cycle+2. A following LD addr=0x108 returns 0xDEADBEEFCAFEF00D.
- Faults: LW addr=0x102, LH addr=0x101, store with funct3=100, load with funct3=111 → each gives done and fault=1 at cycle+1, mem_wr never asserted, load_data unchanged.
- start pulsed every cycle during an LD → only one access occurs; busy stays high until DONE. A second start in the first IDLE cycle after done is accepted.
- SB started, reset asserted during RDW → mem_wr never asserted; next cycle busy=0, done=0, load_data=0.
